// File: rtl/rv32i_fetch.sv
// rv32i_fetch -- instruction fetch stage for the rv32i pipeline.
//
// Holds the program counter and issues in-order word requests to instruction
// memory. Every accepted request reserves one buffer entry, so responses
// never need backpressure. Returned words are presented to decode through a
// registered instruction/pc/valid triple. A redirect from execute flushes the
// buffer. Responses that are still owed for flushed requests are counted in
// r_drop and discarded as they arrive.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  buffer entries / maximum outstanding requests (power of two, >= 2)
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   imem_req_valid/addr/ready       request channel (word-aligned address)
//   imem_rsp_valid/data             in-order response channel, always accepted
//   branch_taken/branch_target      single-cycle redirect from execute
//   fetch_stall                     decode stall; holds the output register
//   fetch_instruction/pc/valid      registered output to decode (NOP when not valid)
//   fetch_misaligned                misaligned-redirect trap flag
//
// Optional feature macro: RV32I_FETCH_MISALIGN_EN
//   defined   : a redirect to a non-word-aligned target raises fetch_misaligned
//               and halts fetching until an aligned redirect or reset.
//   undefined : target bits [1:0] are forced to zero and the trap never fires.

module rv32i_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        fetch_stall,
  output logic [31:0] fetch_instruction,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        fetch_misaligned
);

  localparam int               AW      = $clog2(BUF_DEPTH);
  localparam int               CW      = AW + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  // Program counter, buffer pointers and occupancy
  logic [31:0]   r_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;    // entries holding an accepted request
  logic [CW-1:0] r_nfilled;  // entries (from head) whose response has arrived
  logic [CW-1:0] r_drop;     // responses still owed for flushed requests

  logic [31:0]   r_buf_pc    [BUF_DEPTH];
  logic [31:0]   r_buf_instr [BUF_DEPTH];

  logic [31:0]   r_instr;
  logic [31:0]   r_fpc;
  logic          r_fvalid;
  logic          r_misaligned;
  logic          r_halted;

  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp_keep;
  logic          w_rsp_drop;
  logic          w_head_filled;
  logic          w_pop;
  logic [AW-1:0] w_fill_idx;
  logic [CW-1:0] w_push_ext;
  logic [CW-1:0] w_pop_ext;
  logic [CW-1:0] w_keep_ext;
  logic [CW-1:0] w_rsp_ext;
  logic [31:0]   w_target;
  logic          w_target_mis;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign w_target     = branch_target;
  assign w_target_mis = (branch_target[1:0] != 2'b00);
`else
  assign w_target     = branch_target & 32'hFFFF_FFFC;
  assign w_target_mis = 1'b0;
`endif

  // Credits are counted at request time: an entry is reserved when the
  // request is accepted, and flushed-but-owed responses still hold a credit.
  assign w_req_valid   = !reset && ((r_count + r_drop) < DEPTH_C) && !r_halted;
  assign w_req_fire    = w_req_valid && imem_req_ready;
  assign w_rsp_keep    = imem_rsp_valid && (r_drop == CW'(0));
  assign w_rsp_drop    = imem_rsp_valid && (r_drop != CW'(0));
  assign w_head_filled = (r_nfilled != CW'(0));
  // With nothing filled, a kept response belongs to the head entry and
  // bypasses straight into the output register.
  assign w_pop         = !fetch_stall && (w_head_filled || w_rsp_keep);
  assign w_fill_idx    = r_head + r_nfilled[AW-1:0];

  assign w_push_ext = {{AW{1'b0}}, w_req_fire};
  assign w_pop_ext  = {{AW{1'b0}}, w_pop};
  assign w_keep_ext = {{AW{1'b0}}, w_rsp_keep};
  assign w_rsp_ext  = {{AW{1'b0}}, imem_rsp_valid};

  assign imem_req_valid    = w_req_valid;
  assign imem_req_addr     = r_pc;
  assign fetch_instruction = r_instr;
  assign fetch_pc          = r_fpc;
  assign fetch_valid       = r_fvalid;
  assign fetch_misaligned  = r_misaligned;

  // Buffer storage: request pc at the tail, response word at the oldest unfilled slot
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_buf_pc[r_tail] <= r_pc;
    end
    if (w_rsp_keep) begin
      r_buf_instr[w_fill_idx] <= imem_rsp_data;
    end
  end

  // Control state and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_head       <= AW'(0);
      r_tail       <= AW'(0);
      r_count      <= CW'(0);
      r_nfilled    <= CW'(0);
      r_drop       <= CW'(0);
      r_instr      <= NOP;
      r_fpc        <= RESET_PC;
      r_fvalid     <= 1'b0;
      r_misaligned <= 1'b0;
      r_halted     <= 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall. Everything unfilled, plus a request accepted
      // this cycle, becomes owed; a response this cycle is discarded and pays
      // back one of them.
      r_pc         <= w_target;
      r_head       <= AW'(0);
      r_tail       <= AW'(0);
      r_count      <= CW'(0);
      r_nfilled    <= CW'(0);
      r_drop       <= r_drop + (r_count - r_nfilled) + w_push_ext - w_rsp_ext;
      r_instr      <= NOP;
      r_fvalid     <= 1'b0;
      r_misaligned <= w_target_mis;
      r_halted     <= w_target_mis;
      if (w_target_mis) begin
        r_fpc <= w_target;
      end
    end else begin
      if (w_req_fire) begin
        r_pc   <= r_pc + 32'd4;
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_rsp_drop) begin
        r_drop <= r_drop - CW'(1);
      end
      r_count   <= r_count + w_push_ext - w_pop_ext;
      r_nfilled <= r_nfilled + w_keep_ext - w_pop_ext;
      if (!fetch_stall) begin
        if (w_head_filled) begin
          r_instr  <= r_buf_instr[r_head];
          r_fpc    <= r_buf_pc[r_head];
          r_fvalid <= 1'b1;
        end else if (w_rsp_keep) begin
          r_instr  <= imem_rsp_data;
          r_fpc    <= r_buf_pc[r_head];
          r_fvalid <= 1'b1;
        end else begin
          r_instr  <= NOP;
          r_fvalid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32i_fetch.sv
module tb_rv32i_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        fetch_stall = 1'b0;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_misaligned;

  rv32i_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_stall(fetch_stall),
    .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Memory model: in-order pending responses tagged with the fetch epoch
  logic [31:0] p_addr[$];
  int          p_due[$];
  int          p_ep[$];
  int          last_due = 0;
  int          epoch = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  // Stream reference: next request address, next delivered pc, live words buffered
  logic [31:0] exp_req;
  logic [31:0] exp_next;
  bit          halted_m = 1'b0;
  int          n_buf = 0;
  int          delivered = 0;

  logic        s_rv;
  logic [31:0] s_raddr;

  typedef struct {
    bit          st;
    bit          rd;
    bit          rv;
    logic [31:0] raddr;
    bit          v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[17];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef RV32I_FETCH_MISALIGN_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic bit is_mis(input logic [31:0] t);
`ifdef RV32I_FETCH_MISALIGN_EN
    return (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; fetch_stall = 1'b0; branch_taken = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      p_addr.delete(); p_due.delete(); p_ep.delete();
      n_buf = 0; epoch++;
      #1;
      check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      @(posedge clk); #1; cyc++;
      check32("rst_instr", fetch_instruction, NOP);
      check32("rst_pc", fetch_pc, RPC);
      check32("rst_valid", {31'b0, fetch_valid}, 32'd0);
      check32("rst_mis", {31'b0, fetch_misaligned}, 32'd0);
      check32("rst_req_addr", imem_req_addr, RPC);
    end
    exp_req = RPC; exp_next = RPC; halted_m = 1'b0; last_due = cyc;
  endtask

  // One clock cycle of stimulus with the stream reference checks
  task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit rd);
    logic [31:0] prev_i, prev_p, et;
    bit          prev_v, live, fire, mis;
    int          due;
    @(negedge clk);
    reset = 1'b0; fetch_stall = st; branch_taken = br; branch_target = tgt; imem_req_ready = rd;
    live = 1'b0;
    if (p_due.size() > 0 && p_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(p_addr[0]);
      live = (p_ep[0] == epoch) && !br;
      p_addr.delete(0); p_due.delete(0); p_ep.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (live) n_buf++;
    #1;
    s_rv = imem_req_valid; s_raddr = imem_req_addr;
    fire = s_rv && rd;
    if (halted_m) check32("halt_no_req", {31'b0, s_rv}, 32'd0);
    if (s_rv) check32("req_addr", s_raddr, exp_req);
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      p_addr.push_back(s_raddr); p_due.push_back(due); p_ep.push_back(epoch);
      check32("credit_bound", {31'b0, (p_addr.size() + n_buf) <= DEPTH}, 32'd1);
    end
    mis = br && is_mis(tgt);
    et  = eff_target(tgt);
    if (br) begin
      exp_req = et; epoch++; n_buf = 0; halted_m = mis;
    end else if (fire) begin
      exp_req = exp_req + 32'd4;
    end
    prev_i = fetch_instruction; prev_p = fetch_pc; prev_v = fetch_valid;
    @(posedge clk); #1; cyc++;
    if (br) begin
      check32("redir_valid", {31'b0, fetch_valid}, 32'd0);
      check32("redir_instr", fetch_instruction, NOP);
      check32("redir_mis", {31'b0, fetch_misaligned}, {31'b0, mis});
      if (mis) check32("redir_mis_pc", fetch_pc, tgt);
      exp_next = et;
    end else begin
      check32("mis_hold", {31'b0, fetch_misaligned}, {31'b0, halted_m});
      if (st) begin
        check32("stall_instr", fetch_instruction, prev_i);
        check32("stall_pc", fetch_pc, prev_p);
        check32("stall_valid", {31'b0, fetch_valid}, {31'b0, prev_v});
      end else if (fetch_valid) begin
        check32("stream_pc", fetch_pc, exp_next);
        check32("stream_instr", fetch_instruction, mem_word(exp_next));
        exp_next = exp_next + 32'd4;
        n_buf--; delivered++;
      end else begin
        check32("bubble_instr", fetch_instruction, NOP);
        check32("bubble_pc", fetch_pc, prev_p);
        check32("bubble_nothing_buffered", n_buf, 32'd0);
      end
    end
  endtask

  // Run until the first valid output (bounded) and compare its pc
  task automatic expect_first_valid(input string name, input logic [31:0] pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (fetch_valid) found = 1'b1;
    end
    check32({name, "_found"}, {31'b0, found}, 32'd1);
    if (found) check32({name, "_pc"}, fetch_pc, pc);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'h104, 1'b1, 32'h100};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h108, 1'b1, 32'h104};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h104};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h104};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h104};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h110, 1'b1, 32'h104};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h110, 1'b1, 32'h108};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h110, 1'b1, 32'h10C};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h114, 1'b1, 32'h110};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b1, 32'h114};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b0, 32'h114};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h118, 1'b0, 32'h114};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h118, 1'b0, 32'h114};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h118};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 32'h11C};

    // Table: single-cycle memory, 5-cycle stall, 3 cycles of ready low
    lat_min = 1; lat_max = 1;
    do_reset(2);
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].st, 1'b0, 32'h0, tbl[i].rd);
      check32($sformatf("tbl%0d_req_valid", i), {31'b0, s_rv}, {31'b0, tbl[i].rv});
      check32($sformatf("tbl%0d_req_addr", i), s_raddr, tbl[i].raddr);
      check32($sformatf("tbl%0d_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].v});
      check32($sformatf("tbl%0d_pc", i), fetch_pc, tbl[i].pc);
      check32($sformatf("tbl%0d_instr", i), fetch_instruction, tbl[i].v ? mem_word(tbl[i].pc) : NOP);
    end

    // Redirect to 0x200 with two requests in flight (2-cycle memory)
    lat_min = 2; lat_max = 2;
    do_reset(1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    check32("redir2_bubble_valid", {31'b0, fetch_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("redir2_credits_held", {31'b0, s_rv}, 32'd0);
    expect_first_valid("redir2_target", 32'h200, 20);

    // Simultaneous redirect and stall: redirect wins
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    check32("brstall_valid", {31'b0, fetch_valid}, 32'd0);
    check32("brstall_instr", fetch_instruction, NOP);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("brstall_req_addr", s_raddr, 32'h300);
    expect_first_valid("brstall_target", 32'h300, 20);

    // Misaligned redirect to 0x202
    step(1'b0, 1'b1, 32'h202, 1'b1);
`ifdef RV32I_FETCH_MISALIGN_EN
    check32("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
    check32("mis_pc", fetch_pc, 32'h202);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("mis_halted_req", {31'b0, s_rv}, 32'd0);
    step(1'b0, 1'b1, 32'h300, 1'b1);
    check32("mis_cleared", {31'b0, fetch_misaligned}, 32'd0);
    expect_first_valid("mis_resume", 32'h300, 20);
`else
    check32("mis_flag_tied", {31'b0, fetch_misaligned}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check32("mis_masked_addr", s_raddr, 32'h200);
    expect_first_valid("mis_masked_target", 32'h200, 20);
`endif

    // Randomized run against the stream reference, with one mid-run reset
    lat_min = 1; lat_max = 3;
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom & 32'h0000_0FFC;
      if ($urandom_range(3, 0) == 0) tgt = tgt | 32'($urandom_range(3, 0));
      if (i == 1500) do_reset(2);
      step($urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, tgt, $urandom_range(3, 0) != 0);
    end
    check32("random_throughput", {31'b0, delivered > 300}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
